pulse_stretcher: RTL and testbench

// - Turns single-cycle request pulses (as produced by one_pulse on button/event lines)

---
 rtl/pulse_stretcher_if.sv | 27 ++
 rtl/pulse_stretcher.sv | 97 +++++++++
 tb/tb_pulse_stretcher.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_if.sv
// Request/status bundle for pulse_stretcher: the producer drives in_pulse,
// and the stretcher drives the held level and the queue status back.
interface pulse_stretcher_if #(
    parameter int PEND_W = 3
);
    logic              in_pulse;
    logic              out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output in_pulse,
        input  out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  in_pulse,
        output out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests into HIGH_CYCLES-wide pulses separated by at least
// GAP_CYCLES low cycles, queueing up to PEND_MAX requests that arrive while busy.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 3,
    parameter int PEND_MAX    = 7
) (
    input logic               clk,
    input logic               reset,
    pulse_stretcher_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
    localparam bit                HAS_GAP   = (GAP_CYCLES > 0);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [PEND_W-1:0]  pending, pending_n;
    logic               overflow_n;
    logic               out_r, busy_r, overflow_r;
    logic               last;
    logic               launch;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pending_n  = pending;
        overflow_n = 1'b0;
        last       = (cnt == '0);
        launch     = (state == IDLE) ||
                     (state == GAP && last) ||
                     (state == HIGH && last && !HAS_GAP);

        if (launch) begin
            // A request arriving on a launch edge offsets the queued one being launched.
            if (pending != '0) begin
                state_n = HIGH;
                cnt_n   = HIGH_LOAD;
                if (!bus.in_pulse) begin
                    pending_n = pending - PEND_W'(1);
                end
            end else if (bus.in_pulse) begin
                state_n = HIGH;
                cnt_n   = HIGH_LOAD;
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        end else begin
            if (last) begin
                state_n = GAP;
                cnt_n   = GAP_LOAD;
            end else begin
                cnt_n = cnt - CNT_W'(1);
            end
            if (bus.in_pulse) begin
                if (pending < PEND_FULL) begin
                    pending_n = pending + PEND_W'(1);
                end else begin
                    overflow_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= '0;
            overflow_r <= 1'b0;
            out_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pending    <= pending_n;
            overflow_r <= overflow_n;
            out_r      <= (state_n == HIGH);
            busy_r     <= (state_n != IDLE);
        end
    end

    assign bus.out      = out_r;
    assign bus.busy     = busy_r;
    assign bus.pending  = pending;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a default instance and a GAP_CYCLES=0 instance,
// with hand-derived cycle-by-cycle expectations.
module tb_pulse_stretcher;
    logic clk;
    logic reset;
    int   assertions;
    int   failures;

    pulse_stretcher_if #(.PEND_W(3)) if_a ();
    pulse_stretcher_if #(.PEND_W(3)) if_b ();

    pulse_stretcher dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    pulse_stretcher #(.GAP_CYCLES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After tick() the sampled outputs belong to the cycle following that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        if_a.in_pulse = 1'b1;
        if_b.in_pulse = 1'b1;
        tick();
        if_a.in_pulse = 1'b0;
        if_b.in_pulse = 1'b0;
        tick();
        assertions += 8;
        if (if_a.out !== 1'b0) begin failures++; $display("[TB] FAIL reset_a_out got %b expected 0", if_a.out); end
        if (if_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_a_busy got %b expected 0", if_a.busy); end
        if (if_a.pending !== 3'd0) begin failures++; $display("[TB] FAIL reset_a_pending got %0d expected 0", if_a.pending); end
        if (if_a.overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_a_overflow got %b expected 0", if_a.overflow); end
        if (if_b.out !== 1'b0) begin failures++; $display("[TB] FAIL reset_b_out got %b expected 0", if_b.out); end
        if (if_b.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_b_busy got %b expected 0", if_b.busy); end
        if (if_b.pending !== 3'd0) begin failures++; $display("[TB] FAIL reset_b_pending got %0d expected 0", if_b.pending); end
        if (if_b.overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_b_overflow got %b expected 0", if_b.overflow); end
        reset = 1'b0;
    endtask

    task automatic test_single_pulse();
        logic exp_out, exp_busy;
        for (int e = 0; e < 10; e++) begin
            if_a.in_pulse = (e == 0);
            tick();
            exp_out  = (e + 1 >= 1) && (e + 1 <= 4);
            exp_busy = (e + 1 <= 6);
            assertions += 3;
            if (if_a.out !== exp_out) begin failures++; $display("[TB] FAIL single_out cycle %0d got %b expected %b", e + 1, if_a.out, exp_out); end
            if (if_a.busy !== exp_busy) begin failures++; $display("[TB] FAIL single_busy cycle %0d got %b expected %b", e + 1, if_a.busy, exp_busy); end
            if (if_a.pending !== 3'd0) begin failures++; $display("[TB] FAIL single_pending cycle %0d got %0d expected 0", e + 1, if_a.pending); end
        end
        if_a.in_pulse = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic       exp_out, exp_busy;
        logic [2:0] exp_pend;
        int         c;
        for (int e = 0; e < 19; e++) begin
            if_a.in_pulse = (e <= 2);
            tick();
            c        = e + 1;
            exp_out  = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
            exp_busy = (c <= 18);
            if (e == 0)      exp_pend = 3'd0;
            else if (e == 1) exp_pend = 3'd1;
            else if (e <= 5) exp_pend = 3'd2;
            else if (e <= 11) exp_pend = 3'd1;
            else             exp_pend = 3'd0;
            assertions += 4;
            if (if_a.out !== exp_out) begin failures++; $display("[TB] FAIL b2b_out cycle %0d got %b expected %b", c, if_a.out, exp_out); end
            if (if_a.busy !== exp_busy) begin failures++; $display("[TB] FAIL b2b_busy cycle %0d got %b expected %b", c, if_a.busy, exp_busy); end
            if (if_a.pending !== exp_pend) begin failures++; $display("[TB] FAIL b2b_pending cycle %0d got %0d expected %0d", c, if_a.pending, exp_pend); end
            if (if_a.overflow !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overflow cycle %0d got %b expected 0", c, if_a.overflow); end
        end
        if_a.in_pulse = 1'b0;
    endtask

    // Thirteen held requests: the queue fills, three are dropped, and the final one
    // lands on a launch edge while full, which must not overflow.
    task automatic test_saturate();
        logic [2:0] exp_pend [13] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5,
                                      3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        logic exp_ovf;
        logic prev_out;
        int   launches, drops, waited;
        prev_out = 1'b0;
        launches = 0;
        drops    = 0;
        for (int e = 0; e < 13; e++) begin
            if_a.in_pulse = 1'b1;
            tick();
            exp_ovf = (e >= 9 && e <= 11);
            assertions += 2;
            if (if_a.pending !== exp_pend[e]) begin failures++; $display("[TB] FAIL sat_pending cycle %0d got %0d expected %0d", e + 1, if_a.pending, exp_pend[e]); end
            if (if_a.overflow !== exp_ovf) begin failures++; $display("[TB] FAIL sat_overflow cycle %0d got %b expected %b", e + 1, if_a.overflow, exp_ovf); end
            if (if_a.out && !prev_out) launches++;
            if (if_a.overflow) drops++;
            prev_out = if_a.out;
        end
        if_a.in_pulse = 1'b0;
        waited = 0;
        while ((if_a.busy || if_a.pending != 3'd0) && waited < 100) begin
            tick();
            waited++;
            if (if_a.out && !prev_out) launches++;
            if (if_a.overflow) drops++;
            prev_out = if_a.out;
        end
        assertions += 3;
        if (waited >= 100) begin failures++; $display("[TB] FAIL sat_drain_timeout got busy=%b pending=%0d expected idle", if_a.busy, if_a.pending); end
        if (launches !== 10) begin failures++; $display("[TB] FAIL sat_launches got %0d expected 10", launches); end
        if (drops !== 3) begin failures++; $display("[TB] FAIL sat_drops got %0d expected 3", drops); end
    endtask

    task automatic test_last_gap_request();
        logic exp_out, exp_busy;
        int   c;
        for (int e = 0; e < 13; e++) begin
            if_a.in_pulse = (e == 0) || (e == 6);
            tick();
            c        = e + 1;
            exp_out  = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
            exp_busy = (c <= 12);
            assertions += 3;
            if (if_a.out !== exp_out) begin failures++; $display("[TB] FAIL gapedge_out cycle %0d got %b expected %b", c, if_a.out, exp_out); end
            if (if_a.busy !== exp_busy) begin failures++; $display("[TB] FAIL gapedge_busy cycle %0d got %b expected %b", c, if_a.busy, exp_busy); end
            if (if_a.pending !== 3'd0) begin failures++; $display("[TB] FAIL gapedge_pending cycle %0d got %0d expected 0", c, if_a.pending); end
        end
        if_a.in_pulse = 1'b0;
    endtask

    task automatic test_reset_mid_high();
        for (int e = 0; e < 4; e++) begin
            if_a.in_pulse = 1'b1;
            tick();
        end
        assertions += 2;
        if (if_a.pending !== 3'd3) begin failures++; $display("[TB] FAIL midreset_pre_pending got %0d expected 3", if_a.pending); end
        if (if_a.out !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pre_out got %b expected 1", if_a.out); end
        if_a.in_pulse = 1'b0;
        reset         = 1'b1;
        tick();
        reset = 1'b0;
        assertions += 3;
        if (if_a.out !== 1'b0) begin failures++; $display("[TB] FAIL midreset_out got %b expected 0", if_a.out); end
        if (if_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got %b expected 0", if_a.busy); end
        if (if_a.pending !== 3'd0) begin failures++; $display("[TB] FAIL midreset_pending got %0d expected 0", if_a.pending); end
        for (int e = 0; e < 12; e++) begin
            tick();
            assertions += 2;
            if (if_a.out !== 1'b0) begin failures++; $display("[TB] FAIL postreset_out step %0d got %b expected 0", e, if_a.out); end
            if (if_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL postreset_busy step %0d got %b expected 0", e, if_a.busy); end
        end
    endtask

    task automatic test_zero_gap();
        logic       exp_lvl;
        logic [2:0] exp_pend;
        int         c;
        for (int e = 0; e < 11; e++) begin
            if_b.in_pulse = (e <= 1);
            tick();
            c        = e + 1;
            exp_lvl  = (c >= 1 && c <= 8);
            exp_pend = (e >= 1 && e <= 3) ? 3'd1 : 3'd0;
            assertions += 3;
            if (if_b.out !== exp_lvl) begin failures++; $display("[TB] FAIL nogap_out cycle %0d got %b expected %b", c, if_b.out, exp_lvl); end
            if (if_b.busy !== exp_lvl) begin failures++; $display("[TB] FAIL nogap_busy cycle %0d got %b expected %b", c, if_b.busy, exp_lvl); end
            if (if_b.pending !== exp_pend) begin failures++; $display("[TB] FAIL nogap_pending cycle %0d got %0d expected %0d", c, if_b.pending, exp_pend); end
        end
        if_b.in_pulse = 1'b0;
    endtask

    initial begin
        assertions    = 0;
        failures      = 0;
        reset         = 1'b1;
        if_a.in_pulse = 1'b0;
        if_b.in_pulse = 1'b0;
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_saturate();
        test_last_gap_request();
        test_reset_mid_high();
        test_zero_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
